// File: rtl/acondicionador_entradas.sv
// acondicionador_entradas: input conditioning stage in front of the elevator controller.
// Each of the 14 raw inputs is synchronised with two flops and debounced.
// Debouncing waits for DEBOUNCE_CYCLES consecutive disagreeing samples.
// Rising edges of the debounced level produce one-cycle pulses.
// Channel packing (bit index into the internal 14-bit vectors):
//   [9:0]   botones_raw
//   [11:10] boton_puertas_raw
//   [12]    sensor_piso_raw    (its pulse drives cambio_piso)
//   [13]    sensor_puertas_raw
// Optional feature macro: STUCK_DETECT_EN. When defined, each button channel
// has a saturating hold counter. A button held until that counter saturates
// is flagged on atascado and masked off botones and pulso_botones.
module acondicionador_entradas #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int STUCK_W         = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] botones_raw,
  input  logic [1:0] boton_puertas_raw,
  input  logic       sensor_piso_raw,
  input  logic       sensor_puertas_raw,
  output logic [9:0] botones,
  output logic [9:0] pulso_botones,
  output logic [1:0] boton_puertas,
  output logic       cambio_piso,
  output logic       sensor_puertas,
  output logic [9:0] atascado
);

  localparam int NCH = 14;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw_all;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] stable_q, stable_d;
  logic [NCH-1:0] prev_q;
  logic [NCH-1:0] edge_w;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [9:0] stuck_w;

  assign raw_all = {sensor_puertas_raw, sensor_piso_raw, boton_puertas_raw, botones_raw};

  // Two-flop synchroniser for every raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_all;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing samples; flip stable after DEBOUNCE_CYCLES of them.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce state and the delayed copy of stable used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Rising edge of the debounced level: high during the first cycle stable reads 1.
  assign edge_w = stable_q & ~prev_q;

`ifdef STUCK_DETECT_EN
  logic [STUCK_W-1:0] hold_q [10];
  logic [STUCK_W-1:0] hold_d [10];

  // Hold counter: count up while the button is stable-high, saturate, clear on release.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      hold_d[i] = hold_q[i];
      if (!stable_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != '1) begin
        hold_d[i] = hold_q[i] + STUCK_W'(1);
      end
    end
  end

  // Hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < 10; i++) hold_q[i] <= hold_d[i];
    end
  end

  // Stuck flag drops as soon as stable falls, without waiting for the counter to clear.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      stuck_w[i] = stable_q[i] & (hold_q[i] == '1);
    end
  end
`else
  logic unused_stuck_w;
  assign unused_stuck_w = (STUCK_W > 0);
  assign stuck_w        = '0;
`endif

  // Door-button and obstruction edges are not needed downstream.
  logic unused_edges;
  assign unused_edges = ^{edge_w[13], edge_w[11:10]};

  assign botones        = stable_q[9:0] & ~stuck_w;
  assign pulso_botones  = edge_w[9:0] & ~stuck_w;
  assign atascado       = stuck_w;
  assign boton_puertas  = stable_q[11:10];
  assign cambio_piso    = edge_w[12];
  assign sensor_puertas = stable_q[13];

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Bench for acondicionador_entradas: directed scenarios plus randomized bouncing
// inputs, every cycle compared against a window-based behavioural model.
module tb_acondicionador_entradas;

  localparam int DEB    = 4;
  localparam int CNT_W  = 5;
  localparam int STK_W  = 4;
  localparam int NCH    = 14;
  localparam int W      = 34;

  logic       clk;
  logic       rst_n;
  logic [9:0] botones_raw;
  logic [1:0] boton_puertas_raw;
  logic       sensor_piso_raw;
  logic       sensor_puertas_raw;
  logic [9:0] botones;
  logic [9:0] pulso_botones;
  logic [1:0] boton_puertas;
  logic       cambio_piso;
  logic       sensor_puertas;
  logic [9:0] atascado;

  acondicionador_entradas #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CNT_W),
    .STUCK_W(STK_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .botones_raw(botones_raw),
    .boton_puertas_raw(boton_puertas_raw),
    .sensor_piso_raw(sensor_piso_raw),
    .sensor_puertas_raw(sensor_puertas_raw),
    .botones(botones),
    .pulso_botones(pulso_botones),
    .boton_puertas(boton_puertas),
    .cambio_piso(cambio_piso),
    .sensor_puertas(sensor_puertas),
    .atascado(atascado)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sync pipeline, then "flip once the last DEB synced samples all disagree with the level".
  logic [NCH-1:0] m_s1, m_s2, m_stable, m_prev;
  logic [NCH-1:0] m_hist[$];
  int             m_hold[10];

  function automatic logic [NCH-1:0] raw_vec();
    return {sensor_puertas_raw, sensor_piso_raw, boton_puertas_raw, botones_raw};
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
    m_hist.delete();
    for (int i = 0; i < 10; i++) m_hold[i] = 0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] nstable;
    bool_flip: begin end
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_hist.push_back(m_s2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    nstable = m_stable;
    for (int c = 0; c < NCH; c++) begin
      bit all_diff;
      all_diff = (m_hist.size() == DEB);
      foreach (m_hist[k]) if (m_hist[k][c] == m_stable[c]) all_diff = 0;
      if (all_diff) nstable[c] = ~m_stable[c];
    end
    for (int i = 0; i < 10; i++) begin
      if (!m_stable[i]) m_hold[i] = 0;
      else if (m_hold[i] < (1 << STK_W) - 1) m_hold[i]++;
    end
    m_prev   = m_stable;
    m_stable = nstable;
    m_s2     = m_s1;
    m_s1     = raw_vec();
  endtask

  // Expected outputs packed as {atascado, botones, pulso, puertas, cambio, obst}.
  function automatic logic [W-1:0] model_out();
    logic [9:0] stk, bot, pul;
    logic [NCH-1:0] rise;
    rise = m_stable & ~m_prev;
    stk  = '0;
`ifdef STUCK_DETECT_EN
    for (int i = 0; i < 10; i++)
      stk[i] = m_stable[i] && (m_hold[i] == (1 << STK_W) - 1);
`endif
    bot = m_stable[9:0] & ~stk;
    pul = rise[9:0] & ~stk;
    return {stk, bot, pul, m_stable[11:10], rise[12], m_stable[13]};
  endfunction

  task automatic compare_all(input string pfx);
    logic [W-1:0] e;
    exp_q.push_back(model_out());
    e = exp_q.pop_front();
    check({pfx, "_atascado"}, W'(atascado),       W'(e[33:24]));
    check({pfx, "_botones"},  W'(botones),        W'(e[23:14]));
    check({pfx, "_pulso"},    W'(pulso_botones),  W'(e[13:4]));
    check({pfx, "_puertas"},  W'(boton_puertas),  W'(e[3:2]));
    check({pfx, "_cambio"},   W'(cambio_piso),    W'(e[1]));
    check({pfx, "_obst"},     W'(sensor_puertas), W'(e[0]));
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: advance model, then sample DUT 1 ns later.
  task automatic step(input string pfx);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(pfx);
  endtask

  task automatic set_raw(input logic [NCH-1:0] v);
    {sensor_puertas_raw, sensor_piso_raw, boton_puertas_raw, botones_raw} = v;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_outputs", W'({atascado, botones, pulso_botones, boton_puertas, cambio_piso, sensor_puertas}), '0);
    for (int i = 0; i < cycles; i++) step("in_rst");
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int pulse_cnt;
  logic [9:0] acc;
  int timer[NCH];

  initial begin
    rst_n = 1'b0;
    set_raw('1);
    model_reset();
    #3;

    // TP1: all inputs high through reset.
    async_reset(3);
    for (int i = 1; i <= 5; i++) step("tp1");
    check("tp1_pulso_edge5", W'(pulso_botones), '0);
    step("tp1");
    check("tp1_pulso_edge6",   W'(pulso_botones), W'(10'h3FF));
    check("tp1_botones_edge6", W'(botones),       W'(10'h3FF));
    check("tp1_cambio_edge6",  W'(cambio_piso),   W'(1'b1));
    step("tp1");
    check("tp1_pulso_edge7",   W'(pulso_botones), '0);
    check("tp1_cambio_edge7",  W'(cambio_piso),   '0);
    set_raw('0);
    for (int i = 0; i < 10; i++) step("tp1_idle");

    // TP2: single button press held 12 cycles.
    botones_raw[3] = 1'b1;
    for (int i = 1; i <= 6; i++) step("tp2");
    check("tp2_pulso", W'(pulso_botones), W'(10'h008));
    check("tp2_botones", W'(botones), W'(10'h008));
    step("tp2");
    check("tp2_pulso_once", W'(pulso_botones), '0);
    for (int i = 8; i <= 12; i++) step("tp2");
    botones_raw[3] = 1'b0;
    acc = '0;
    for (int i = 1; i <= 5; i++) begin step("tp2_rel"); acc |= pulso_botones; end
    check("tp2_still_high_edge5", W'(botones[3]), W'(1'b1));
    step("tp2_rel");
    acc |= pulso_botones;
    check("tp2_low_edge6", W'(botones[3]), '0);
    check("tp2_no_fall_pulse", W'(acc), '0);

    // TP3: 3-cycle glitch on botones_raw[7].
    acc = '0;
    botones_raw[7] = 1'b1;
    for (int i = 0; i < 3; i++) begin step("tp3"); acc |= pulso_botones | botones; end
    botones_raw[7] = 1'b0;
    for (int i = 0; i < 10; i++) begin step("tp3"); acc |= pulso_botones | botones; end
    check("tp3_glitch_rejected", W'(acc), '0);

    // TP4: bouncing floor sensor gives exactly one cambio_piso.
    pulse_cnt = 0;
    sensor_piso_raw = 1'b1; step("tp4"); pulse_cnt += int'(cambio_piso);
    sensor_piso_raw = 1'b0; step("tp4"); pulse_cnt += int'(cambio_piso);
    sensor_piso_raw = 1'b1;
    for (int i = 0; i < 11; i++) begin step("tp4"); pulse_cnt += int'(cambio_piso); end
    sensor_piso_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin step("tp4"); pulse_cnt += int'(cambio_piso); end
    check("tp4_one_pulse", W'(pulse_cnt), W'(1));

    // TP5: reset mid-count, raw still high after release.
    botones_raw[0] = 1'b1;
    step("tp5"); step("tp5");
    #2;
    async_reset(2);
    for (int i = 1; i <= 5; i++) step("tp5");
    step("tp5");
    check("tp5_pulso_edge6", W'(pulso_botones), W'(10'h001));
    botones_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) step("tp5_idle");

    // Long hold: exercises hold counters when the stuck option is built in.
    botones_raw[2] = 1'b1;
    for (int i = 0; i < 30; i++) step("hold");
`ifdef STUCK_DETECT_EN
    check("hold_atascado", W'(atascado[2]), W'(1'b1));
`else
    check("hold_atascado_off", W'(atascado), '0);
`endif
    botones_raw[2] = 1'b0;
    for (int i = 0; i < 10; i++) step("hold_rel");
    check("hold_rel_atascado", W'(atascado), '0);

    // Random phase: per-channel random hold lengths, short ones act as bounces.
    for (int c = 0; c < NCH; c++) timer[c] = $urandom_range(1, 9);
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [NCH-1:0] v;
      v = raw_vec();
      for (int c = 0; c < NCH; c++) begin
        timer[c]--;
        if (timer[c] <= 0) begin
          if ($urandom_range(0, 1) == 1) v[c] = ~v[c];
          timer[c] = $urandom_range(1, 12);
        end
      end
      set_raw(v);
      if (cyc % 200 == 150) async_reset($urandom_range(1, 3));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
